// File: rtl/div16_seq_if.sv
// ---------------------------------------------------------------------------
// div16_seq_if -- request/result bundle for the 16-bit sequential divider.
//
// Signals:
//    start      request pulse (master -> slave)
//    dividend   16-bit unsigned numerator (master -> slave)
//    divisor    16-bit unsigned denominator (master -> slave)
//    quotient   16-bit registered quotient (slave -> master)
//    remainder  16-bit registered remainder (slave -> master)
//    busy       divider is working or presenting a result (slave -> master)
//    done       one-cycle result-valid pulse (slave -> master)
//    div_zero   last accepted request had a zero divisor (slave -> master)
//
// Modports: master = requester, slave = divider.
// ---------------------------------------------------------------------------
interface div16_seq_if;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_zero
   );
endinterface

// File: rtl/div16_seq.sv
// ---------------------------------------------------------------------------
// div16_seq -- 16-bit unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//    clk    rising-edge clock for all state
//    rst_n  asynchronous active-low reset
//    bus    div16_seq_if.slave: start/dividend/divisor in,
//           quotient/remainder/busy/done/div_zero out
//
// A start seen in IDLE captures the operands. A zero divisor goes straight
// to DONE with quotient=FFFF, remainder=dividend and div_zero set. Otherwise
// sixteen CALC cycles produce the quotient MSB-first, after which DONE
// presents the result for one cycle and the block returns to IDLE.
// ---------------------------------------------------------------------------
module div16_seq (
   input  logic        clk,
   input  logic        rst_n,
   div16_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [15:0] r_dvd;     // dividend, shifted left so bit 15 is the next bit to bring down
   logic [15:0] r_dvs;     // captured divisor
   logic [15:0] r_part;    // partial remainder; always < divisor so 16 bits suffice between steps
   logic [15:0] r_qw;      // quotient being assembled
   logic [4:0]  r_cnt;     // iteration counter 0..15
   logic [15:0] r_quo;
   logic [15:0] r_rem;
   logic        r_dz;

   logic        w_busy;
   logic        w_done;
   logic [16:0] w_step;
   logic        w_qbit;
   logic [15:0] w_part_nx;
   logic        w_last;

   // One restoring step: shift in the next dividend bit to form a 17-bit
   // value, subtract the divisor by two's complement, and keep the difference
   // only when it did not go negative (bit 16 clear). Returns {qbit, part}.
   function automatic logic [16:0] f_step(input logic [15:0] part_in,
                                          input logic        bit_in,
                                          input logic [15:0] dvs);
      logic [16:0] sh;
      logic [16:0] diff;
      sh   = {part_in, bit_in};
      diff = sh + ~{1'b0, dvs} + 17'd1;
      if (!diff[16])
         f_step = {1'b1, diff[15:0]};
      else
         f_step = {1'b0, sh[15:0]};
   endfunction

   assign w_step    = f_step(r_part, r_dvd[15], r_dvs);
   assign w_qbit    = w_step[16];
   assign w_part_nx = w_step[15:0];
   assign w_last    = (r_cnt == 5'd15);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start)
               w_next = (bus.divisor != 16'd0) ? S_CALC : S_DONE;
         end
         S_CALC: begin
            if (w_last)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_CALC: w_busy = 1'b1;
         S_DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_part <= '0;
         r_qw   <= '0;
         r_cnt  <= '0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_dz   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_dvd  <= bus.dividend;
                  r_dvs  <= bus.divisor;
                  r_part <= '0;
                  r_qw   <= '0;
                  r_cnt  <= '0;
                  if (bus.divisor == 16'd0) begin
                     // Zero divisor: results are loaded on the accepting edge.
                     r_quo <= 16'hFFFF;
                     r_rem <= bus.dividend;
                     r_dz  <= 1'b1;
                  end else begin
                     r_dz  <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_dvd  <= {r_dvd[14:0], 1'b0};
               r_part <= w_part_nx;
               r_qw   <= {r_qw[14:0], w_qbit};
               r_cnt  <= r_cnt + 5'd1;
               if (w_last) begin
                  r_quo <= {r_qw[14:0], w_qbit};
                  r_rem <= w_part_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient  = r_quo;
   assign bus.remainder = r_rem;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.div_zero  = r_dz;

endmodule

// File: tb/tb_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_div16_seq -- self-checking bench for div16_seq.
// Expected results are queued when a request is driven and compared when
// done is seen; latency, done width, busy and reset behaviour are checked
// along the way.
// ---------------------------------------------------------------------------
module tb_div16_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   div16_seq_if bus ();

   div16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one request, then wait for and check its result.
   task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input bit inject);
      exp_t        e;
      logic [15:0] q_prev;
      logic [15:0] r_prev;
      logic [31:0] prod;
      int          n;
      bit          busy_ok;

      if (dvs == 16'd0) begin
         e.q  = 16'hFFFF;
         e.r  = dvd;
         e.dz = 1'b1;
      end else begin
         e.q  = dvd / dvs;
         e.r  = dvd % dvs;
         e.dz = 1'b0;
      end
      sb.push_back(e);

      q_prev       = bus.quotient;
      r_prev       = bus.remainder;
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      tick;
      // Operands change after capture; they must not matter.
      bus.start    = 1'b0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'($urandom);

      chk("div_zero_on_accept", 32'(bus.div_zero), 32'(dvs == 16'd0));
      if (dvs != 16'd0) begin
         chk("quotient_held", 32'(bus.quotient), 32'(q_prev));
         chk("remainder_held", 32'(bus.remainder), 32'(r_prev));
      end

      n       = 0;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && n < 40) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (inject && n == 3) begin
            bus.start    = 1'b1;
            bus.dividend = 16'd50;
            bus.divisor  = 16'd5;
         end else begin
            bus.start = 1'b0;
         end
         tick;
         n++;
      end
      bus.start = 1'b0;

      chk("latency", 32'(n), (dvs == 16'd0) ? 32'd0 : 32'd16);
      chk("busy_during_calc", 32'(busy_ok), 32'd1);
      chk("busy_in_done", 32'(bus.busy), 32'd1);

      e = sb.pop_front();
      chk("quotient", 32'(bus.quotient), 32'(e.q));
      chk("remainder", 32'(bus.remainder), 32'(e.r));
      chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
      if (dvs != 16'd0) begin
         prod = {16'd0, bus.quotient} * {16'd0, dvs} + {16'd0, bus.remainder};
         chk("identity", prod, {16'd0, dvd});
         chk("rem_lt_div", 32'(bus.remainder < dvs), 32'd1);
      end

      tick;
      chk("done_width", 32'(bus.done), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   function automatic logic [15:0] pick();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0:       pick = 16'h0000;
         1:       pick = 16'hFFFF;
         2:       pick = 16'h0001;
         default: pick = 16'($urandom);
      endcase
   endfunction

   initial begin
      bit seen_done;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;

      // Reset state
      repeat (2) tick;
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
      rst_n = 1'b1;
      tick;

      // Directed cases
      run_op(16'd100, 16'd7, 1'b0);
      run_op(16'hFFFF, 16'd1, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 1'b0);
      run_op(16'd5, 16'd0, 1'b0);
      run_op(16'd7, 16'd1, 1'b0);
      run_op(16'd3, 16'd9, 1'b1);

      // Reset during CALC aborts the operation
      bus.start    = 1'b1;
      bus.dividend = 16'd1000;
      bus.divisor  = 16'd3;
      tick;
      bus.start = 1'b0;
      repeat (8) tick;
      chk("mid_calc_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_remainder", 32'(bus.remainder), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_div_zero", 32'(bus.div_zero), 32'd0);
      repeat (3) tick;
      rst_n     = 1'b1;
      seen_done = 1'b0;
      repeat (20) begin
         tick;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
      end
      chk("no_done_after_abort", 32'(seen_done), 32'd0);
      run_op(16'd1000, 16'd3, 1'b0);

      // Random sweep, back-to-back
      for (int i = 0; i < 3000; i++) begin
         run_op(pick(), pick(), 1'b0);
      end

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
